// File: rtl/modinv_p24_pkg.sv
// Shared constants and state type for the p = 2^24-3 modular inverter.
// Optional feature macro: MODINV_P24_ZERO_ERR_EN (see modinv_p24.sv).
package modinv_p24_pkg;

   localparam int W  = 24;
   localparam int PW = 48;
   localparam int IW = 5;

   localparam logic [W-1:0] P   = 24'hFFFFFD;
   localparam logic [W-1:0] EXP = 24'hFFFFFB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mulred_p24.sv
// Combinational 24x24 multiply reduced mod p = 2^24-3 to a canonical result.
module mulred_p24
   import modinv_p24_pkg::*;
(
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] z
);

   logic [PW-1:0] prod_s;
   logic [W+1:0]  fold1_s;
   logic [W:0]    fold2_s;

   // Multiply, fold the high half twice using 2^24 == 3, then one conditional subtract
   always_comb begin
      prod_s  = {24'd0, x} * {24'd0, y};
      fold1_s = {2'b00, prod_s[W-1:0]} + {2'b00, prod_s[PW-1:W]} + {1'b0, prod_s[PW-1:W], 1'b0};
      // second fold leaves at most 2^24+8, which is below 2p
      fold2_s = {1'b0, fold1_s[W-1:0]} + {23'd0, fold1_s[W+1:W]} + {22'd0, fold1_s[W+1:W], 1'b0};
      if (fold2_s >= {1'b0, P}) begin
         z = fold2_s[W-1:0] - P;
      end else begin
         z = fold2_s[W-1:0];
      end
   end

endmodule

// File: rtl/modinv_p24.sv
// Sequential modular inverter m = a^(p-2) mod p, one field multiply per cycle.
// Define MODINV_P24_ZERO_ERR_EN to add the zero_err port and a one-cycle zero-operand path.
module modinv_p24
   import modinv_p24_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] m
`ifdef MODINV_P24_ZERO_ERR_EN
   ,
   output logic         zero_err
`endif
);

   state_t        state_r;
   logic [W-1:0]  r_r;
   logic [W-1:0]  base_r;
   logic [IW-1:0] idx_r;
   logic          out_valid_r;
   logic [W-1:0]  a_red_s;
   logic [W-1:0]  op_b_s;
   logic [W-1:0]  prod_s;
   logic          zero_skip_s;

   // Pre-reduce the operand and pick the second multiplier input
   always_comb begin
      if (a >= P) begin
         a_red_s = a - P;
      end else begin
         a_red_s = a;
      end
      if (state_r == MUL) begin
         op_b_s = base_r;
      end else begin
         op_b_s = r_r;
      end
   end

   mulred_p24 u_mulred (
      .x (r_r),
      .y (op_b_s),
      .z (prod_s)
   );

`ifdef MODINV_P24_ZERO_ERR_EN
   logic zero_r;
   logic zero_err_r;

   // Remember a zero operand and raise zero_err alongside the early result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         zero_r     <= 1'b0;
         zero_err_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: if (in_valid) zero_r <= (a_red_s == 24'd0);
            SQR:  if (zero_r) zero_err_r <= 1'b1;
            DONE: if (out_ready) zero_err_r <= 1'b0;
            default: zero_r <= zero_r;
         endcase
      end
   end

   assign zero_skip_s = zero_r;
   assign zero_err    = zero_err_r;
`else
   assign zero_skip_s = 1'b0;
`endif

   // Square-and-multiply sequencer over exponent bits 22..0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         r_r         <= 24'd0;
         base_r      <= 24'd0;
         idx_r       <= 5'd0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  base_r  <= a_red_s;
                  r_r     <= a_red_s;
                  idx_r   <= 5'd22;
                  state_r <= SQR;
               end
            end
            SQR: begin
               if (zero_skip_s) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  r_r <= prod_s;
                  if (EXP[idx_r]) begin
                     state_r <= MUL;
                  end else if (idx_r == 5'd0) begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                  end else begin
                     idx_r <= idx_r - 5'd1;
                  end
               end
            end
            MUL: begin
               r_r <= prod_s;
               if (idx_r == 5'd0) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  idx_r   <= idx_r - 5'd1;
                  state_r <= SQR;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign m         = r_r;

endmodule
